// File: rtl/uart_pkg.sv
// Shared defaults and launch-FSM state encoding for the UART transmit FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, registered occupancy flags, sticky overflow.
// Latency: a push is visible on rd_data/empty after one edge; a pop frees the slot after one edge.
// Backpressure: pushes while full are dropped and set overflow; pops while empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              push;
    logic              pop;

    // Acceptance uses the registered flags, so a byte pushed into an empty FIFO
    // cannot be popped on the same edge and a pop never makes room for a same-edge push.
    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    // Next-state for pointers, occupancy and overflow; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
            if (wr_en && full_q) ovf_d = 1'b1;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter with a one-cycle tx_start launch pulse per byte.
// Latency: push into an idle, empty FIFO with tx_ready high gives tx_start after the next edge.
// Backpressure: launches wait for tx_ready to drop and return high; FIFO drops pushes when full.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_ready
);

    tx_state_e         state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_pop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (fifo_pop),
        .flush    (flush),
        .rd_data  (fifo_head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Launch FSM: pop head and pulse tx_start, then track the UART busy/idle handshake.
    // A launch is held off during flush so a byte being discarded is never transmitted.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && tx_ready && !flush) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_head;
                    tx_start_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (!tx_ready) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (tx_ready)  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered UART-facing outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       full, empty, overflow, tx_start, tx_ready;
    logic [4:0] count;
    logic [7:0] tx_data;

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, sticky overflow, accepted and launched streams.
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] rx[$];
    bit         ovf_m = 1'b0;
    int         starts = 0, bad_start = 0, uart_viol = 0, width_err = 0, maxc = 0;
    logic       prev_start = 1'b0;

    // UART model
    bit   uart_auto = 1'b0;
    int   frame_len = 10;
    int   busy = 0;
    logic uart_rdy = 1'b1;
    logic man_rdy = 1'b1;

    assign tx_ready = uart_auto ? uart_rdy : man_rdy;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // Behavioural UART: a frame keeps tx_ready low for frame_len cycles after tx_start.
    always @(negedge clk) begin
        if (uart_auto) begin
            if (busy > 0) begin
                busy <= busy - 1;
                if (busy == 1) uart_rdy <= 1'b1;
            end else if (tx_start) begin
                uart_rdy <= 1'b0;
                busy     <= frame_len;
            end
        end else begin
            uart_rdy <= 1'b1;
            busy     <= 0;
        end
    end

    // One clock of stimulus; inputs change at negedge, outputs sampled at the next negedge.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic fl);
        int pre;
        wr_en = wr; wr_data = d; flush = fl;
        pre = mq.size();
        @(posedge clk);
        @(negedge clk);
        if (fl) begin
            mq.delete();
            ovf_m = 1'b0;
        end else if (wr) begin
            if (pre < DEPTH) begin
                mq.push_back(d);
                sent.push_back(d);
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (tx_start) begin
            starts++;
            if (prev_start) width_err++;
            if (uart_auto && busy > 0) uart_viol++;
            if (pre == 0 || fl) bad_start++;
            else begin
                rx.push_back(tx_data);
                void'(mq.pop_front());
            end
        end
        prev_start = tx_start;
        if (int'(count) > maxc) maxc = int'(count);
        wr_en = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0)    begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        man_rdy = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0);
        checks++; if (int'(count) !== mq.size()) begin errors++; $display("FAIL single_count_n got %0d want %0d", count, mq.size()); end
        checks++; if (empty !== 1'b0)    begin errors++; $display("FAIL single_empty_n got %b want 0", empty); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_n got %b want 0", tx_start); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_n1 got %b want 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL single_empty_n1 got %b want 1", empty); end
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width got %b want 0", tx_start); end
        man_rdy = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        man_rdy = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_full_overflow();
        man_rdy = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i == 15) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at15 got %b want 0", full); end
            end
        end
        checks++; if (full !== 1'b1)      begin errors++; $display("FAIL full_at16 got %b want 1", full); end
        checks++; if (count !== 5'd16)    begin errors++; $display("FAIL count_at16 got %0d want 16", count); end
        checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL ovf_before got %b want %b", overflow, ovf_m); end
        cycle(1'b1, 8'h11, 1'b0);
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_after17 got %b want 1", overflow); end
        checks++; if (int'(count) !== mq.size()) begin errors++; $display("FAIL count_after17 got %0d want %0d", count, mq.size()); end
        // push while full with a same-edge pop: push still dropped
        man_rdy = 1'b1;
        cycle(1'b1, 8'h12, 1'b0);
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL full_pop got start=%b data=%h want 1/01", tx_start, tx_data); end
        checks++; if (int'(count) !== mq.size()) begin errors++; $display("FAIL full_pushpop_count got %0d want %0d", count, mq.size()); end
        checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL full_pushpop_ovf got %b want %b", overflow, ovf_m); end
        man_rdy = 1'b0;
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_flush();
        int s0;
        cycle(1'b0, 8'h00, 1'b1);
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL flush1_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL flush1_ovf got %b want 0", overflow); end
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
        checks++; if (int'(count) !== mq.size()) begin errors++; $display("FAIL flush_pre5 got %0d want %0d", count, mq.size()); end
        s0 = starts;
        cycle(1'b1, 8'hEE, 1'b1);
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL flush2_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL flush2_empty got %b want 1", empty); end
        checks++; if (overflow !== ovf_m) begin errors++; $display("FAIL flush2_ovf got %b want %b", overflow, ovf_m); end
        checks++; if (tx_data !== 8'h01)  begin errors++; $display("FAIL flush2_txdata got %h want 01", tx_data); end
        man_rdy = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        checks++; if (starts !== s0)      begin errors++; $display("FAIL flush_nolaunch got %0d want %0d", starts, s0); end
    endtask

    task automatic test_uart_order();
        int s0;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        uart_auto = 1'b1; frame_len = 10;
        rx.delete();
        s0 = starts;
        for (int i = 0; i < 3; i++) cycle(1'b1, exp_b[i], 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00, 1'b0);
        checks++; if (starts - s0 !== 3)  begin errors++; $display("FAIL uart_starts got %0d want 3", starts - s0); end
        checks++; if (rx.size() !== 3)    begin errors++; $display("FAIL uart_rx_size got %0d want 3", rx.size()); end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            checks++; if (rx[i] !== exp_b[i]) begin errors++; $display("FAIL uart_byte%0d got %h want %h", i, rx[i], exp_b[i]); end
        end
        checks++; if (uart_viol !== 0)    begin errors++; $display("FAIL uart_busy_launch got %0d want 0", uart_viol); end
        checks++; if (width_err !== 0)    begin errors++; $display("FAIL uart_pulse_width got %0d want 0", width_err); end
    endtask

    task automatic test_reset_midframe();
        int s0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h41 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        checks++; if (count !== 5'd3 || mq.size() !== 3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
        #2 reset_n = 1'b0;
        #1;
        mq.delete(); ovf_m = 1'b0; prev_start = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got c=%0d e=%b f=%b want 0/1/0", count, empty, full); end
        checks++; if (overflow !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_out got o=%b s=%b d=%h want 0/0/00", overflow, tx_start, tx_data); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        s0 = starts;
        for (int i = 0; i < 30; i++) cycle(1'b0, 8'h00, 1'b0);
        checks++; if (starts !== s0)      begin errors++; $display("FAIL mid_no_launch got %0d want %0d", starts, s0); end
        cycle(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b0);
        checks++; if (starts !== s0 + 1)  begin errors++; $display("FAIL mid_relaunch got %0d want %0d", starts, s0 + 1); end
        checks++; if (rx.size() == 0 || rx[$] !== 8'h5A) begin errors++; $display("FAIL mid_relaunch_data got %h want 5a", (rx.size() == 0) ? 8'hxx : rx[$]); end
    endtask

    task automatic test_stream();
        int guard;
        int bs0;
        logic w;
        rx.delete(); sent.delete();
        maxc = 0; bs0 = bad_start; guard = 0;
        while (sent.size() < 40 && guard < 3000) begin
            frame_len = $urandom_range(2, 4);
            w = ($urandom_range(0, 3) != 0);
            cycle(w, 8'($urandom), 1'b0);
            checks++; if (int'(count) !== mq.size()) begin errors++; $display("FAIL stream_count got %0d want %0d", count, mq.size()); end
            guard++;
        end
        while (mq.size() > 0 && guard < 3000) begin
            cycle(1'b0, 8'h00, 1'b0);
            guard++;
        end
        checks++; if (guard >= 3000)      begin errors++; $display("FAIL stream_timeout got %0d cycles want <3000", guard); end
        checks++; if (rx.size() !== 40)   begin errors++; $display("FAIL stream_rx_size got %0d want 40", rx.size()); end
        for (int i = 0; i < rx.size() && i < sent.size(); i++) begin
            checks++; if (rx[i] !== sent[i]) begin errors++; $display("FAIL stream_byte%0d got %h want %h", i, rx[i], sent[i]); end
        end
        checks++; if (maxc > DEPTH)       begin errors++; $display("FAIL stream_maxcount got %0d want <=16", maxc); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL stream_drained got c=%0d e=%b want 0/1", count, empty); end
        checks++; if (bad_start !== bs0 || uart_viol !== 0 || width_err !== 0) begin errors++; $display("FAIL stream_protocol got bad=%0d viol=%0d width=%0d want 0", bad_start - bs0, uart_viol, width_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_flush();
        test_uart_order();
        test_reset_midframe();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
